// File: rtl/pixel_frame_streamer_pkg.sv
// pixel_frame_streamer_pkg: state encoding, GRB field layout and sizing helpers shared by the pixel pipeline.
package pixel_frame_streamer_pkg;
   typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, SEND, LATCH} state_t;
   localparam int G_LSB = 16;
   localparam int R_LSB = 8;
   localparam int B_LSB = 0;
   function automatic int frame_ticks(input int clk_hz, input int hz);
      return clk_hz / hz;
   endfunction
   function automatic int addr_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
   // scaling by brightness+1 keeps 255 an exact identity; the product never reaches bit 16
   function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
      return 8'((17'(c) * (17'(b) + 17'd1)) >> 8);
   endfunction
endpackage

// File: rtl/pixel_frame_streamer_timer.sv
// pixel_frame_streamer_timer: free-running frame tick generator with sticky overrun detection.
module pixel_frame_streamer_timer
   import pixel_frame_streamer_pkg::*;
#(
   parameter int CLK_HZ = 16000000,
   parameter int HZ = 80
) (
   input  logic clk,
   input  logic rst_n,
   input  logic busy,
   output logic tick,
   output logic overrun
);
   localparam int FT = frame_ticks(CLK_HZ, HZ);
   localparam int CW = addr_w(FT);
   logic [CW-1:0] count;
   assign tick = count == CW'(FT - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         count <= '0;
         overrun <= 1'b0;
      end else begin
         count <= tick ? '0 : count + 1'b1;
         overrun <= overrun | (tick & busy);
      end
endmodule

// File: rtl/pixel_frame_streamer.sv
// pixel_frame_streamer: reads a GRB frame from RAM each frame tick, scales it and issues
// one valid/ready colour command per pixel followed by a latch command.
module pixel_frame_streamer
   import pixel_frame_streamer_pkg::*;
#(
   parameter int CLK_HZ = 16000000,
   parameter int HZ = 80,
   parameter int LED = 256,
   parameter int ADDR_W = addr_w(LED)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [7:0]        brightness,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [23:0]       rd_data,
   output logic [7:0]        red,
   output logic [7:0]        green,
   output logic [7:0]        blue,
   output logic              px_reset,
   output logic              valid,
   input  logic              ready,
   output logic              busy,
   output logic              frame_done,
   output logic              overrun
);
   localparam logic [ADDR_W:0] NUM = (ADDR_W + 1)'(LED);
   localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(LED - 1);
   state_t state, state_nx;
   logic tick, xfer, use_rd, pf_full, pf_pend;
   logic [ADDR_W:0] rd_ptr, px_cnt;
   logic [23:0] pf, px_in;
   pixel_frame_streamer_timer #(.CLK_HZ(CLK_HZ), .HZ(HZ)) u_timer (
      .clk(clk),
      .rst_n(rst_n),
      .busy(busy),
      .tick(tick),
      .overrun(overrun)
   );
   assign px_in = {scale(rd_data[G_LSB +: 8], brightness), scale(rd_data[R_LSB +: 8], brightness),
                   scale(rd_data[B_LSB +: 8], brightness)};
   assign rd_addr = rd_ptr[ADDR_W-1:0];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = tick && enable ? FETCH : IDLE;
         FETCH:   state_nx = CAPTURE;
         CAPTURE: state_nx = SEND;
         SEND:    state_nx = xfer && px_cnt == LAST ? LATCH : SEND;
         LATCH:   state_nx = xfer ? IDLE : LATCH;
         default: state_nx = IDLE;
      endcase
   end
   // while a pixel waits on ready, the next one is fetched into the prefetch slot
   always_comb begin
      busy = state != IDLE;
      xfer = valid && ready;
      frame_done = state == LATCH && xfer;
      rd_en = state == FETCH || (state == SEND && rd_ptr < NUM && !pf_full && !pf_pend);
      use_rd = state == SEND && !valid && !pf_full && pf_pend;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rd_ptr <= '0;
         px_cnt <= '0;
         pf <= '0;
         pf_full <= 1'b0;
         pf_pend <= 1'b0;
         valid <= 1'b0;
         px_reset <= 1'b0;
         {green, red, blue} <= '0;
      end else begin
         pf_pend <= rd_en && state == SEND;
         if (state == IDLE) begin
            rd_ptr <= '0;
            px_cnt <= '0;
            pf_full <= 1'b0;
         end
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         if (xfer) begin
            valid <= 1'b0;
            px_reset <= 1'b0;
            px_cnt <= px_cnt + 1'b1;
         end
         if (state == CAPTURE || use_rd) begin
            {green, red, blue} <= px_in;
            valid <= 1'b1;
         end else if (pf_pend) begin
            pf <= px_in;
            pf_full <= 1'b1;
         end
         if (state == SEND && !valid && pf_full) begin
            {green, red, blue} <= pf;
            valid <= 1'b1;
            pf_full <= 1'b0;
         end
         if (state == LATCH && !valid) begin
            {green, red, blue} <= '0;
            px_reset <= 1'b1;
            valid <= 1'b1;
         end
      end
endmodule
